// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle ops plus iterative unsigned multiply/divide.
// Results are held in output registers behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             div_by_zero_o
);
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d, res_q, res_d, hi_q, hi_d;
  logic                 dbz_q, dbz_d;
  logic                 accept;
  logic [SHAMT_W-1:0]   sh;
  logic [WIDTH-1:0]     alu;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   step;

  assign in_ready_o    = !reset && (state_q == IDLE || (state_q == DONE && out_ready_i));
  assign accept        = in_valid_i && in_ready_o;
  assign out_valid_o   = state_q == DONE;
  assign result_o      = res_q;
  assign result_hi_o   = hi_q;
  assign div_by_zero_o = dbz_q;
  assign sh            = b_i[SHAMT_W-1:0];

  always_comb begin
    alu = '0;
    case (op_i)
      4'd0:    alu = a_i + b_i;
      4'd1:    alu = a_i - b_i;
      4'd2:    alu = a_i << sh;
      4'd3:    alu = a_i >> sh;
      4'd4:    alu = $unsigned($signed(a_i) >>> sh);
      4'd5:    alu = (a_i << sh) | (a_i >> (WIDTH - int'(sh)));
      4'd6:    alu = (a_i >> sh) | (a_i << (WIDTH - int'(sh)));
      4'd7:    alu = a_i & b_i;
      4'd8:    alu = a_i | b_i;
      4'd9:    alu = a_i ^ b_i;
      4'd10:   alu = ~(a_i | b_i);
      4'd11:   alu = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      4'd12:   alu = {{(WIDTH-1){1'b0}}, a_i < b_i};
      4'd15:   alu = ~a_i & b_i;
      default: alu = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign step     = state_q == MUL ? {mul_sum, acc_q[WIDTH-1:1]} :
                    div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                                      {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
    case (state_q)
      MUL, DIV: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = step[WIDTH-1:0];
          hi_d    = step[2*WIDTH-1:WIDTH];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = state_q;
    endcase
    if (accept) begin
      if (op_i == 4'd13) begin
        state_d = MUL;
        cnt_d   = '1;
        acc_d   = {{WIDTH{1'b0}}, b_i};
        opnd_d  = a_i;
      end else if (op_i == 4'd14 && b_i != '0) begin
        state_d = DIV;
        cnt_d   = '1;
        acc_d   = {{WIDTH{1'b0}}, a_i};
        opnd_d  = b_i;
      end else begin
        state_d = DONE;
        res_d   = op_i == 4'd14 ? '1 : alu;
        hi_d    = op_i == 4'd14 ? a_i : '0;
        dbz_d   = op_i == 4'd14;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
    end
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the core's execute stage, carrying the single-cycle integer operations forward and adding iterative unsigned multiply and divide. Operands and opcode arrive over a valid/ready handshake, and each result is held in an output register until the downstream stage accepts it. Single-cycle operations sustain one result per cycle. MULU and DIVU occupy the block for WIDTH iterations.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- SHAMT_W, $clog2(WIDTH), derived localparam; width of the shift/rotate amount
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high reset
- in_valid_i  in  1  op_i/a_i/b_i valid
- in_ready_o  out  1  block accepts an operation this cycle
- op_i  in  4  operation select:
  - 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 ROL, 6 ROR, 7 AND
  - 8 OR, 9 XOR, 10 NOR, 11 SLT, 12 SLTU, 13 MULU, 14 DIVU, 15 ANOT
- a_i  in  WIDTH  first operand
- b_i  in  WIDTH  second operand; shifts and rotates use b_i[SHAMT_W-1:0]
- out_valid_o  out  1  result registers valid
- out_ready_i  in  1  consumer accepts the result
- result_o  out  WIDTH  result; low product for MULU; quotient for DIVU
- result_hi_o  out  WIDTH  high product for MULU; remainder for DIVU; 0 for all other ops
- div_by_zero_o  out  1  DIVU with b_i == 0; 0 for all other ops

## Operation
- Handshakes:
  - An operation is accepted on a clock edge where in_valid_i && in_ready_o.
  - A result is consumed on a clock edge where out_valid_o && out_ready_i.
- State machine (all results leave through DONE):
  - IDLE: accept.
    - Single-cycle op: register the result, go to DONE.
    - MULU: load the operands, count = WIDTH-1, go to MUL.
    - DIVU with b != 0: load the operands, count = WIDTH-1, go to DIV.
    - DIVU with b == 0: go straight to DONE.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator. At count == 0, write result_hi_o:result_o and go to DONE. Otherwise decrement count.
  - DIV: restoring division, one quotient bit per cycle, MSB first. At count == 0, write quotient and remainder and go to DONE.
  - DONE: out_valid_o = 1.
    - On consume without a new accept, go to IDLE.
    - On consume with a simultaneous accept, behave as IDLE for the new operation.
- in_ready_o = (state == IDLE) || (state == DONE && out_ready_i), forced to 0 while reset is high. This is a combinational path from out_ready_i to in_ready_o.
- Inputs are sampled only at accept; later changes to a_i, b_i or op_i have no effect.
- Arithmetic and width rules (all results modulo 2^WIDTH):
  - ADD and SUB wrap.
  - SLT is signed and SLTU unsigned; the result is 1 or 0, zero-extended.
  - SRA is an arithmetic right shift.
  - ROL and ROR rotate by b[SHAMT_W-1:0]; an amount of 0 returns a unchanged.
  - NOR = ~(a|b); ANOT = ~a & b.
- Divide by zero: result_o = all ones, result_hi_o = a, div_by_zero_o = 1.
- Output registers hold their value while out_valid_o && !out_ready_i. The consumer may stall indefinitely.

## Timing
- Reset (asynchronous, any time):
  - State goes to IDLE; count, result_o, result_hi_o, div_by_zero_o = 0; out_valid_o = 0.
  - An operation in flight is discarded and produces no output.
- Single-cycle ops, and DIVU by zero: accepted at edge N, out_valid_o = 1 after edge N.
- MULU and DIVU (b != 0):
  - Accepted at edge N, out_valid_o = 1 after edge N+WIDTH (latency WIDTH+1 edges).
  - in_ready_o = 0 throughout the MUL/DIV iterations.
- Back-to-back single-cycle ops with out_ready_i held at 1: one result per cycle, no bubble.
- out_valid_o deasserts on the edge after a consume unless a new single-cycle result is loaded on that same edge.

## Test plan
- Reset mid-MULU:
  - Stimulus: accept MULU a=7, b=9; assert reset 5 cycles later.
  - Required response: out_valid_o = 0, in_ready_o = 0 during reset, all outputs 0; after release, in_ready_o = 1 and no stale result ever appears.
- Single-cycle sweep, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → 0.
  - SUB 0-1 → 0xFFFFFFFF.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - ROR 0x00000001 by 1 → 0x80000000.
  - ROL 0x12345678 by 0 → 0x12345678.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
  - ANOT a=0x0F, b=0xFF → 0xF0.
- MULU 0xFFFFFFFF × 0xFFFFFFFF:
  - Required response: after 33 edges, result_hi_o = 0xFFFFFFFE, result_o = 0x00000001; in_ready_o stays low for the 32 iteration cycles.
- DIVU 100 / 7 → result_o = 14, result_hi_o = 2, div_by_zero_o = 0.
- DIVU 5 / 0 → one-cycle latency, result_o = 0xFFFFFFFF, result_hi_o = 5, div_by_zero_o = 1.
- Backpressure and streaming:
  - Hold out_ready_i = 0 for 10 cycles after an ADD result: result stays stable and in_ready_o = 0.
  - Then stream 8 ADDs with out_ready_i = 1: 8 results arrive on consecutive cycles, in order.
